// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out deserializer: assembles WIDTH-bit words from a bit stream
// and presents them on a registered output with a valid/ack handshake.
module sipo_receiver #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             frame_start,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned   CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] start_word;
    logic             complete;

    logic [WIDTH-1:0] data_out_next;
    logic             data_valid_next;
    logic             overrun_next;
    logic             busy_next;

    // Shift-in and fresh-word images for the configured bit order.
    assign shifted    = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
    assign start_word = MSB_FIRST ? WIDTH'(din) : {din, {(WIDTH-1){1'b0}}};

    // State register: FSM state, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr    <= sr_next;
        end
    end

    // Next state: frame_start restarts the word with din as its first bit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        complete   = 1'b0;
        if (din_valid) begin
            if (frame_start) begin
                sr_next    = start_word;
                cnt_next   = CW'(1);
                state_next = SHIFT;
            end else begin
                sr_next = shifted;
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next   = cnt + CW'(1);
                    state_next = SHIFT;
                end
            end
        end
    end

    // Output next values: a completing word always loads; overrun only if unacked.
    always_comb begin
        data_out_next   = data_out;
        data_valid_next = data_valid;
        overrun_next    = overrun;
        busy_next       = (state_next == SHIFT);
        if (complete) begin
            data_out_next   = sr_next;
            data_valid_next = 1'b1;
            if (data_valid && !data_ack) begin
                overrun_next = 1'b1;
            end
        end else if (data_valid && data_ack) begin
            data_valid_next = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_out   <= data_out_next;
            data_valid <= data_valid_next;
            overrun    <= overrun_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_sipo_receiver.sv
// Bench for sipo_receiver: cycle-exact vector table on MSB- and LSB-first instances,
// then a scoreboarded word stream with gapped input.
module tb_sipo_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dv  = 1'b0;
    logic       din = 1'b0;
    logic       fs  = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] d_m;
    logic [3:0] d_l;
    logic       v_m, o_m, b_m;
    logic       v_l, o_l, b_l;

    always #5 clk = ~clk;

    sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(rst), .din_valid(dv), .din(din), .frame_start(fs),
        .data_ack(ack), .data_out(d_m), .data_valid(v_m), .overrun(o_m), .busy(b_m)
    );

    sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(rst), .din_valid(dv), .din(din), .frame_start(fs),
        .data_ack(ack), .data_out(d_l), .data_valid(v_l), .overrun(o_l), .busy(b_l)
    );

    typedef struct {
        logic       rst, dv, din, fs, ack;
        logic [3:0] em, el;
        logic       ev, eo, eb;
    } vec_t;

    typedef struct {
        logic [3:0] m;
        logic [3:0] l;
    } word_t;

    vec_t  vecs[$];
    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    sb_on = 1'b0;
    logic  prev_v = 1'b0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic b, input logic f,
                       input logic a, input logic [3:0] em, input logic [3:0] el,
                       input logic ev, input logic eo, input logic eb);
        vec_t x;
        x.rst = r; x.dv = v; x.din = b; x.fs = f; x.ack = a;
        x.em = em; x.el = el; x.ev = ev; x.eo = eo; x.eb = eb;
        vecs.push_back(x);
    endtask

    // One clock; sample 1 time unit after the edge and pop the scoreboard on new words.
    task automatic step();
        word_t w;
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (v_m && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_word", 4'(v_m), 4'd0);
                end else begin
                    w = sb.pop_front();
                    chk("sb_word_msb", d_m, w.m);
                    chk("sb_word_lsb", d_l, w.l);
                end
            end
            prev_v = v_m;
        end
    endtask

    // Send m[3] first; expected LSB-first image is the bit reversal of m.
    task automatic send_word(input logic [3:0] m, input int gap);
        word_t w;
        for (int i = 3; i >= 0; i--) begin
            dv  = 1'b1;
            din = m[i];
            if (i == 0) begin
                w.m = m;
                w.l = {m[0], m[1], m[2], m[3]};
                sb.push_back(w);
            end
            step();
            dv = 1'b0;
            if (i != 0) begin
                chk("busy_mid_word", 4'(b_m), 4'd1);
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("busy_in_gap", 4'(b_m), 4'd1);
                end
            end else begin
                chk("busy_after_word", 4'(b_m), 4'd0);
            end
        end
    endtask

    initial begin
        // rst dv din fs ack | data_m data_l valid ovr busy
        add(1,0,0,0,0, 4'h0,4'h0, 0,0,0);
        // word assembly 1011
        add(0,1,1,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,0,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 1,0,0);
        add(0,0,0,0,1, 4'hB,4'hD, 0,0,0);
        add(0,0,0,0,1, 4'hB,4'hD, 0,0,0);
        // overrun: 1011 then 0101 back-to-back, no ack
        add(0,1,1,0,0, 4'hB,4'hD, 0,0,1);
        add(0,1,0,0,0, 4'hB,4'hD, 0,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 0,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 1,0,0);
        add(0,1,0,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,0,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,1,0,0, 4'h5,4'hA, 1,1,0);
        add(0,0,0,0,1, 4'h5,4'hA, 0,1,0);
        add(1,0,0,0,0, 4'h0,4'h0, 0,0,0);
        // same with ack on the completion edge of 0101
        add(0,1,1,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,0,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 1,0,0);
        add(0,1,0,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,1,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,0,0,0, 4'hB,4'hD, 1,0,1);
        add(0,1,1,0,1, 4'h5,4'hA, 1,0,0);
        add(0,0,0,0,1, 4'h5,4'hA, 0,0,0);
        // resync: 1,1 discarded, frame_start with 0, then 1,1,0
        add(0,1,1,0,0, 4'h5,4'hA, 0,0,1);
        add(0,1,1,0,0, 4'h5,4'hA, 0,0,1);
        add(0,1,0,1,0, 4'h5,4'hA, 0,0,1);
        add(0,1,1,0,0, 4'h5,4'hA, 0,0,1);
        add(0,1,1,0,0, 4'h5,4'hA, 0,0,1);
        add(0,1,0,0,0, 4'h6,4'h6, 1,0,0);
        // frame_start without din_valid mid-word is ignored; ack on completion edge
        add(0,1,1,0,0, 4'h6,4'h6, 1,0,1);
        add(0,1,1,0,0, 4'h6,4'h6, 1,0,1);
        add(0,0,0,1,0, 4'h6,4'h6, 1,0,1);
        add(0,1,0,0,0, 4'h6,4'h6, 1,0,1);
        add(0,1,1,0,1, 4'hD,4'hB, 1,0,0);
        // reset mid-word with a pending word, reset overriding all inputs
        add(0,1,1,0,0, 4'hD,4'hB, 1,0,1);
        add(0,1,0,0,0, 4'hD,4'hB, 1,0,1);
        add(1,1,1,1,1, 4'h0,4'h0, 0,0,0);
        add(0,1,0,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,0,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'h0,4'h0, 0,0,1);
        add(0,1,1,0,0, 4'h3,4'hC, 1,0,0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; dv = vecs[i].dv; din = vecs[i].din;
            fs  = vecs[i].fs;  ack = vecs[i].ack;
            step();
            chk($sformatf("v%0d_data_m", i), d_m, vecs[i].em);
            chk($sformatf("v%0d_data_l", i), d_l, vecs[i].el);
            chk($sformatf("v%0d_valid_m", i), 4'(v_m), 4'(vecs[i].ev));
            chk($sformatf("v%0d_valid_l", i), 4'(v_l), 4'(vecs[i].ev));
            chk($sformatf("v%0d_ovr_m", i), 4'(o_m), 4'(vecs[i].eo));
            chk($sformatf("v%0d_ovr_l", i), 4'(o_l), 4'(vecs[i].eo));
            chk($sformatf("v%0d_busy_m", i), 4'(b_m), 4'(vecs[i].eb));
            chk($sformatf("v%0d_busy_l", i), 4'(b_l), 4'(vecs[i].eb));
        end

        // Scoreboarded phase: consumer always acks, so valid pulses once per word.
        rst = 1'b1; dv = 1'b0; fs = 1'b0; ack = 1'b0;
        step();
        rst    = 1'b0;
        ack    = 1'b1;
        prev_v = 1'b0;
        sb_on  = 1'b1;
        send_word(4'b1011, 2);
        send_word(4'b1000, 0);
        for (int k = 0; k < 24; k++) begin
            send_word(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 8 && sb.size() != 0; k++) begin
            step();
        end
        chk("sb_drained", 4'(sb.size()), 4'd0);
        chk("no_overrun_with_ack", 4'(o_m), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
